aes_inv_cipher_iter: RTL
========================

Name: aes_inv_cipher_iter

Overview:
Iterative, parametrised AES inverse cipher that decrypts one 128-bit block at a time from a precomputed, expanded round-key bus. It generalises the fixed 10-round decryptor to AES-128/192/256 through NR, and to 1 or 2 rounds per clock through RPC. It adds valid/ready handshakes on input and output, plus an optional CBC chaining mode with an IV register. It sits between the key-expansion unit and the host data path.

Parameters:
NR, 10, number of rounds; legal values 10, 12, 14.
RPC, 1, inverse rounds evaluated per clock; legal values 1 or 2; must divide NR.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  ciphertext block offered
in_ready  out  1  core can accept a block
in_data  in  128  ciphertext; byte 0 is bits [127:120], FIPS-197 column-major
round_keys  in  (NR+1)*128  expanded schedule; round 0 key in the top 128 bits, round NR key in the bottom 128 bits
cbc_en  in  1  sampled on accept; 1 = CBC, 0 = ECB
iv_load  in  1  load the chain register from iv
iv  in  128  initialisation vector
out_valid  out  1  plaintext available
out_ready  in  1  consumer takes the plaintext
out_data  out  128  plaintext
busy  out  1  high while in RUN

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1, out_valid=0, busy=0. out_data, working state, chain register and round counter are all cleared to 0. A reset mid-RUN or mid-DONE discards the block; no output is ever produced for it.
- FSM IDLE / RUN / DONE. in_ready = (state==IDLE). busy = (state==RUN).
- IDLE, on in_valid & in_ready at edge k:
  - work <= in_data ^ rk[NR]; rnd <= NR.
  - mode <= cbc_en; xor_val <= chain; chain <= in_data when cbc_en=1.
  - Go to RUN.
- RUN, each edge:
  - Apply RPC inverse rounds in sequence. Each round is InvShiftRows, InvSubBytes, AddRoundKey(rk[rnd-1]), then InvMixColumns unless rnd-1==0.
  - rnd decrements by RPC.
  - When rnd reaches 0: out_data <= work_result ^ (mode ? xor_val : 0); go to DONE.
- Latency: out_valid rises after edge k+NR/RPC. Examples: NR=10,RPC=1 gives 10 cycles; NR=14,RPC=2 gives 7 cycles.
- DONE: out_valid=1 and out_data is held stable until out_valid & out_ready at an edge, then IDLE. in_ready rises the cycle after. There is no same-cycle accept-on-drain.
- round_keys are not latched. The source must hold them stable from the accept edge until out_valid. Changing them mid-RUN gives undefined plaintext but must not upset the FSM.
- iv_load is honoured only in IDLE (chain <= iv) and ignored otherwise.
  - iv_load coincident with accept: the new iv is the XOR value for that block, and chain then becomes in_data.
- In ECB blocks (cbc_en=0) chain is left unchanged, so ECB and CBC blocks may be interleaved.
- in_valid while not IDLE is ignored; the block is not consumed.
- Any illegal NR/RPC combination is rejected at elaboration with a fatal assertion.

Decomposition:
- Package aes_pkg holds:
  - the 128-bit block typedef and byte-array state typedef;
  - the inverse S-box constant table;
  - xtime and the gf_mul9/11/13/14 functions;
  - the round-key slicing function rk(bus, i);
  - the FSM state enum.
- Sub-module aes_inv_round: a combinational single inverse round with inputs state, round key and last flag. It is instantiated RPC times in a chain.
- The top level holds the FSM, counter, chain/xor registers and handshakes.

Test Plan:
1. NR=10, RPC=1, ECB, key 000102..0f schedule, in_data 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after accept.
2. NR=10, key "Thats my Kung Fu" schedule, in_data 29c3505f571420f6402299b31a02d73a → 54776f204f6e65204e696e652054776f. Hold out_ready=0 for 5 cycles: out_data stable and in_ready=0 throughout.
3. CBC, key 2b7e151628aed2a6abf7158809cf4f3c, iv_load with iv 000102..0f. Block 7649abac8119b246cee98e9b12e9197d → 6bc1bee22e409f96e93d7e117393172a. Next block 5086cb9b507219ee95db113a917678b2 → ae2d8a571e03ac9c9eb76fac45af8e51.
4. NR=14, RPC=2, key 000102..1f schedule, in_data 8ea2b7ca516745bfeafc49904b496089 → 00112233..ff, out_valid 7 cycles after accept.
5. Assert rst for 1 cycle at the 4th RUN cycle → out_valid stays 0 and in_ready=1 immediately after reset. A fresh run of scenario 1 then passes.
6. Drive in_valid during RUN with a different block, and iv_load during DONE → neither is consumed. The result equals scenario 3, block 1.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, inverse S-box, GF(2^8) helpers and round-key slicing
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [7:0]   state_t [16];
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam int RK_MAX_ROUNDS = 14;
    localparam int RK_BUS_W      = (RK_MAX_ROUNDS + 1) * 128;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sub(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Bus is left-aligned: round 0 always occupies the top 128 bits.
    function automatic block_t rk(input logic [RK_BUS_W-1:0] bus, input logic [3:0] i);
        return bus[RK_BUS_W-1-128*int'(i) -: 128];
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last,
    output logic [127:0] state_out
);

    state_t s_in;
    state_t s_key;
    state_t s_ark;
    state_t s_out;

    // Byte index is 4*column + row; byte 0 sits in bits [127:120].
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            s_in[i]  = state_in[127-8*i -: 8];
            s_key[i] = round_key[127-8*i -: 8];
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s_ark[4*c+r] = inv_sub(s_in[4*((c - r + 4) % 4) + r]) ^ s_key[4*c+r];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) s_out[4*c+r] = s_ark[4*c+r];
            end else begin
                s_out[4*c+0] = gf_mul14(s_ark[4*c]) ^ gf_mul11(s_ark[4*c+1]) ^ gf_mul13(s_ark[4*c+2]) ^ gf_mul9(s_ark[4*c+3]);
                s_out[4*c+1] = gf_mul9(s_ark[4*c])  ^ gf_mul14(s_ark[4*c+1]) ^ gf_mul11(s_ark[4*c+2]) ^ gf_mul13(s_ark[4*c+3]);
                s_out[4*c+2] = gf_mul13(s_ark[4*c]) ^ gf_mul9(s_ark[4*c+1])  ^ gf_mul14(s_ark[4*c+2]) ^ gf_mul11(s_ark[4*c+3]);
                s_out[4*c+3] = gf_mul11(s_ark[4*c]) ^ gf_mul13(s_ark[4*c+1]) ^ gf_mul9(s_ark[4*c+2])  ^ gf_mul14(s_ark[4*c+3]);
            end
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) state_out[127-8*i -: 8] = s_out[i];
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128/192/256 decryptor with ECB/CBC and valid/ready
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR  = 10,
    parameter int RPC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_data,
    input  logic [(NR+1)*128-1:0] round_keys,
    input  logic                  cbc_en,
    input  logic                  iv_load,
    input  logic [127:0]          iv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy
);

    if (!((NR == 10 || NR == 12 || NR == 14) && (RPC == 1 || RPC == 2) && (NR % RPC == 0))) begin : g_bad_params
        $fatal(1, "aes_inv_cipher_iter: illegal NR/RPC combination");
    end

    localparam logic [3:0] NR_W  = 4'(NR);
    localparam logic [3:0] RPC_W = 4'(RPC);

    fsm_t                  state;
    block_t                work;
    block_t                xor_val;
    block_t                chain;
    logic [3:0]            rnd;
    logic                  mode;
    logic [RK_BUS_W-1:0]   rk_bus;
    logic [RPC:0][127:0]   stage;

    always_comb begin
        rk_bus = '0;
        rk_bus[RK_BUS_W-1 -: (NR+1)*128] = round_keys;
    end

    assign stage[0] = work;

    // Stage j applies round rnd-1-j; the round that lands on key 0 skips InvMixColumns.
    for (genvar j = 0; j < RPC; j++) begin : g_round
        logic [3:0] key_idx;
        assign key_idx = rnd - 4'd1 - 4'(j);
        aes_inv_round u_round (
            .state_in (stage[j]),
            .round_key(rk(rk_bus, key_idx)),
            .last     (key_idx == 4'd0),
            .state_out(stage[j+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            work      <= '0;
            chain     <= '0;
            xor_val   <= '0;
            rnd       <= '0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iv_load) chain <= iv;
                    if (in_valid && in_ready) begin
                        work     <= in_data ^ rk(rk_bus, NR_W);
                        rnd      <= NR_W;
                        mode     <= cbc_en;
                        xor_val  <= iv_load ? iv : chain;
                        if (cbc_en) chain <= in_data;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    work <= stage[RPC];
                    rnd  <= rnd - RPC_W;
                    if (rnd == RPC_W) begin
                        out_data  <= stage[RPC] ^ (mode ? xor_val : '0);
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
